// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with RISC-V load/store formatting, 1-cycle read latency, sequenced clear after reset.
// Optional DMEM_STATS_EN adds stat_loads/stat_stores/stat_errs counters.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errs
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [AW-1:0]     clr_cnt;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rd_word;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              ld_q;

  logic              accept;
  logic [ADDR_W-3:0] widx;
  logic [AW-1:0]     midx;
  logic [1:0]        lane;
  logic              in_range;
  logic              bad;
  logic              do_store;
  logic              do_load;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       sh;

  assign accept   = req_valid && req_ready;
  assign widx     = req_addr[ADDR_W-1:2];
  assign midx     = widx[AW-1:0];
  assign lane     = req_addr[1:0];
  assign in_range = (widx >> AW) == '0;
  assign bad      = (req_size == 2'b11) || (req_size == 2'b01 && lane[0]) ||
                    (req_size == 2'b10 && lane != 2'b00) || !in_range;
  assign do_store = accept && req_we && !bad;
  assign do_load  = accept && !req_we && !bad;

  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    case (req_size)
      2'b00: begin be = 4'b0001 << lane; wd = {4{req_wdata[7:0]}};  end
      2'b01: begin be = 4'b0011 << lane; wd = {2{req_wdata[15:0]}}; end
      2'b10: begin be = 4'b1111;         wd = req_wdata;            end
      default: begin be = 4'b0000;       wd = req_wdata;            end
    endcase
  end

  // Storage has no reset; the CLEAR sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (do_store) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[midx][8*b +: 8] <= wd[8*b +: 8];
    end
    if (do_load) rd_word <= mem[midx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ld_q      <= 1'b0;
      lane_q    <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && bad;
      ld_q      <= do_load;
      if (do_load) begin
        lane_q <= lane;
        size_q <= req_size;
        uns_q  <= req_unsigned;
      end
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
            state     <= READY;
            req_ready <= 1'b1;
          end
        end
        default: req_ready <= 1'b1;
      endcase
    end
  end

  // Lane shift and extension happen after the registered read, keeping the RAM read port plain.
  always_comb begin
    sh        = rd_word >> {lane_q, 3'b000};
    rsp_rdata = '0;
    if (ld_q) begin
      case (size_q)
        2'b00:   rsp_rdata = uns_q ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
        2'b01:   rsp_rdata = uns_q ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        default: rsp_rdata = rd_word;
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else begin
      if (do_load)       stat_loads  <= stat_loads + 1'b1;
      if (do_store)      stat_stores <= stat_stores + 1'b1;
      if (accept && bad) stat_errs   <= stat_errs + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu (DEPTH_WORDS=16) against a byte-array reference model.
module tb_dmem_lsu;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] model [DEPTH*4];

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_err(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || a / 4 >= DEPTH;
  endfunction

  // Build the expected load value from individual bytes of the model.
  function automatic logic [31:0] load_val(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int v;
    if (sz == 2'd0) begin
      v = model[a];
      if (!uns && v >= 128) v -= 256;
    end else if (sz == 2'd1) begin
      v = model[a] + 256 * model[a+1];
      if (!uns && v >= 32768) v -= 65536;
    end else begin
      v = model[a] + 256 * model[a+1] + 65536 * model[a+2] + 16777216 * model[a+3];
    end
    return 32'(v);
  endfunction

  task automatic xfer(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wdat);
    logic        e;
    logic [31:0] exp;
    int          n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wdat;
    e   = is_err(sz, a);
    exp = (e || we) ? 32'h0 : load_val(sz, uns, a);
    check({tag, ".rdy"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, ".vld"}, 32'(rsp_valid), 32'd1);
    check({tag, ".err"}, 32'(rsp_err), 32'(e));
    check({tag, ".dat"}, rsp_rdata, exp);
    if (we && !e) begin
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int i = 0; i < n; i++) model[a+i] = wdat[8*i +: 8];
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check(tag, 32'(rsp_valid), 32'd0);
  endtask

  // Release reset at a negedge and count rising edges until req_ready rises.
  task automatic release_and_count(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (req_ready) break;
      check({tag, ".vld0"}, 32'(rsp_valid), 32'd0);
    end
    check({tag, ".clr_cycles"}, 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH*4; i++) model[i] = 8'h00;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, ".rdy"}, 32'(req_ready), 32'd0);
    check({tag, ".vld"}, 32'(rsp_valid), 32'd0);
    check({tag, ".err"}, 32'(rsp_err), 32'd0);
    check({tag, ".dat"}, rsp_rdata, 32'd0);
`ifdef DMEM_STATS_EN
    check({tag, ".sl"}, stat_loads, 32'd0);
    check({tag, ".ss"}, stat_stores, 32'd0);
    check({tag, ".se"}, stat_errs, 32'd0);
`endif
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset");
    release_and_count("clr1");

    for (int i = 0; i < DEPTH; i++) xfer("zero", 1'b0, 2'd2, 1'b0, 32'(4*i), 32'h0);

    xfer("sw8", 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    xfer("lw8", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    xfer("sb5", 1'b1, 2'd0, 1'b0, 32'h5, 32'h80);
    xfer("lb5", 1'b0, 2'd0, 1'b0, 32'h5, 32'h0);
    xfer("lbu5", 1'b0, 2'd0, 1'b1, 32'h5, 32'h0);
    xfer("lw4", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    check("lw4.lit", rsp_rdata, 32'h00008000);
    xfer("sh2", 1'b1, 2'd1, 1'b0, 32'h2, 32'h1234);
    xfer("lw0", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    check("lw0.lit", rsp_rdata, 32'h12340000);
    xfer("lhu2", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0);
    xfer("lh1", 1'b0, 2'd1, 1'b0, 32'h1, 32'h0);
    check("lh1.err", 32'(rsp_err), 32'd1);
    xfer("sw6", 1'b1, 2'd2, 1'b0, 32'h6, 32'h11111111);
    xfer("swoor", 1'b1, 2'd2, 1'b0, 32'(DEPTH*4), 32'h11111111);
    xfer("lw4b", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    xfer("lw0b", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    xfer("sz3", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    idle_cycle("idle0");

    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) sz = 2'd3;
      else if (sz == 2'd3) sz = 2'd2;
      a = 32'($urandom_range(0, DEPTH*4 + 7));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 5) == 0) idle_cycle("rnd.idle");
      else xfer("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Fill memory, reset mid-CLEAR, and confirm the restarted clear zeroes everything.
    for (int i = 0; i < DEPTH; i++) xfer("fill", 1'b1, 2'd2, 1'b0, 32'(4*i), $urandom | 32'h1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outs("midclr");
    release_and_count("clr2");
    for (int i = 0; i < DEPTH; i++) xfer("zero2", 1'b0, 2'd2, 1'b0, 32'(4*i), 32'h0);

    // Reset with a load response in flight.
    xfer("sw_pend", 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D);
    xfer("lw_pend", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    #1 rst = 1'b1;
    #1 check_reset_outs("pend");
    release_and_count("clr3");
    xfer("lw_after", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
